// File: rtl/ascon_loader.sv
// Operand loader for the Ascon permutation controller. It takes a header byte
// that selects the operation, then assembles 16 or 48 payload bytes MSB-first
// into three 128-bit operand registers, and issues a launch strobe once the
// downstream controller is idle.
module ascon_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic         load_abort,
  input  logic         core_idle,
  output logic [127:0] reg0_128b,
  output logic [127:0] reg1_128b,
  output logic [127:0] reg2_128b,
  output logic [2:0]   operation_mode,
  output logic         operation_ready,
  output logic         mode_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

  state_e       state_q, state_d;
  logic [5:0]   cnt_q;
  logic         long_q;      // 1: 48-byte load (encrypt/decrypt), 0: 16-byte load
  logic [127:0] reg0_q, reg1_q, reg2_q;
  logic [2:0]   mode_q;
  logic         mode_err_q;

  logic         hdr_long, hdr_short;
  logic         hdr_take, hdr_bad, byte_take, launch;
  logic [5:0]   last_idx;
  logic [6:0]   byte_lsb;

  assign hdr_long  = (data_in[2:0] == 3'b001) || (data_in[2:0] == 3'b010);
  assign hdr_short = (data_in[2:0] == 3'b011) || (data_in[2:0] == 3'b100) ||
                     (data_in[2:0] == 3'b101);
  assign last_idx  = long_q ? 6'd47 : 6'd15;
  // Byte k%16 lands at bits [127-8*(k%16) -: 8], i.e. LSB index 8*(15-k%16).
  assign byte_lsb  = {~cnt_q[3:0], 3'b000};

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_d   = state_q;
    hdr_take  = 1'b0;
    hdr_bad   = 1'b0;
    byte_take = 1'b0;
    launch    = 1'b0;
    case (state_q)
      StIdle: begin
        // An abort in IDLE suppresses header acceptance for that cycle.
        if (data_valid && !load_abort) begin
          if (hdr_long || hdr_short) begin
            hdr_take = 1'b1;
            state_d  = StLoad;
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      StLoad: begin
        if (load_abort) begin
          state_d = StIdle;
        end else if (data_valid) begin
          byte_take = 1'b1;
          if (cnt_q == last_idx) state_d = StReady;
        end
      end
      StReady: begin
        if (load_abort) begin
          state_d = StIdle;
        end else if (core_idle) begin
          launch  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand registers, byte counter, mode and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= 6'd0;
      long_q     <= 1'b0;
      reg0_q     <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      mode_q     <= 3'b000;
      mode_err_q <= 1'b0;
    end else begin
      mode_err_q <= hdr_bad;
      if (hdr_take) begin
        mode_q <= data_in[2:0];
        long_q <= hdr_long;
        cnt_q  <= 6'd0;
        reg0_q <= '0;
        reg1_q <= '0;
        reg2_q <= '0;
      end else if (byte_take) begin
        cnt_q <= cnt_q + 6'd1;
        case (cnt_q[5:4])
          2'd0:    reg0_q[byte_lsb +: 8] <= data_in;
          2'd1:    reg1_q[byte_lsb +: 8] <= data_in;
          2'd2:    reg2_q[byte_lsb +: 8] <= data_in;
          default: ;
        endcase
      end
    end
  end

  // Ready is forced high while reset is asserted so upstream sees a clean IDLE.
  assign data_ready      = !rst_n || (state_q != StReady);
  assign operation_ready = rst_n && launch;
  assign mode_err        = mode_err_q;
  assign reg0_128b       = reg0_q;
  assign reg1_128b       = reg1_q;
  assign reg2_128b       = reg2_q;
  assign operation_mode  = mode_q;

endmodule

// File: tb/tb_ascon_loader.sv
// Testbench for ascon_loader: directed scenarios plus randomized loads, with
// a queue of expected launch / mode-error events checked by a monitor.
module tb_ascon_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         load_abort = 1'b0;
  logic         core_idle = 1'b1;
  logic [127:0] reg0_128b, reg1_128b, reg2_128b;
  logic [2:0]   operation_mode;
  logic         operation_ready;
  logic         mode_err;

  ascon_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .load_abort      (load_abort),
    .core_idle       (core_idle),
    .reg0_128b       (reg0_128b),
    .reg1_128b       (reg1_128b),
    .reg2_128b       (reg2_128b),
    .operation_mode  (operation_mode),
    .operation_ready (operation_ready),
    .mode_err        (mode_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit           is_err;
    logic [2:0]   mode;
    logic [127:0] r0, r1, r2;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: the operation mode and the list of payload bytes
  // accepted since the last header; registers are derived from that list.
  logic [2:0] m_mode = 3'b000;
  logic [7:0] m_bytes[$];

  function automatic logic [127:0] m_reg(input int idx);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int k = idx * 16 + i;
      r = {r[119:0], (k < m_bytes.size()) ? m_bytes[k] : 8'h00};
    end
    return r;
  endfunction

  function automatic ev_t mk_ev(input bit is_err);
    ev_t e;
    e.is_err = is_err;
    e.mode   = m_mode;
    e.r0     = m_reg(0);
    e.r1     = m_reg(1);
    e.r2     = m_reg(2);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic chk_regs(input string name);
    chk({name, "_reg0"}, reg0_128b, m_reg(0));
    chk({name, "_reg1"}, reg1_128b, m_reg(1));
    chk({name, "_reg2"}, reg2_128b, m_reg(2));
    chk({name, "_mode"}, 128'(operation_mode), 128'(m_mode));
  endtask

  // Monitor: every launch strobe or mode error must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (operation_ready || mode_err) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: operation_ready=%b mode_err=%b, none expected",
                 operation_ready, mode_err);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 128'({mode_err, operation_ready}), 128'({e.is_err, !e.is_err}));
        chk("event_mode", 128'(operation_mode), 128'(e.mode));
        chk("event_reg0", reg0_128b, e.r0);
        chk("event_reg1", reg1_128b, e.r1);
        chk("event_reg2", reg2_128b, e.r2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    data_valid = 1'b0;
    data_in    = 8'($urandom);
    step();
  endtask

  function automatic bit good_mode(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd5);
  endfunction

  task automatic send_hdr(input logic [7:0] h);
    data_valid = 1'b1;
    data_in    = h;
    chk("hdr_data_ready", 128'(data_ready), 128'(1'b1));
    if (good_mode(h[2:0])) begin
      m_mode = h[2:0];
      m_bytes.delete();
    end else begin
      exp_q.push_back(mk_ev(1'b1));
    end
    step();
    data_valid = 1'b0;
  endtask

  // pat: 0 incrementing, 1 all 0xFF, 2 random. gap: 0 none, 1 alternate, 2 random.
  // abort_at == target aborts while waiting in READY; -1 disables abort/reset.
  task automatic do_load(input logic [7:0] hdr, input int pat, input int gap,
                         input int hold, input int abort_at, input int reset_at);
    int         target;
    logic [7:0] b;
    send_hdr(hdr);
    target    = (hdr[2:0] == 3'b001 || hdr[2:0] == 3'b010) ? 48 : 16;
    core_idle = (hold == 0);
    for (int k = 0; k < target; k++) begin
      if (gap == 1 && k > 0) idle_cycle();
      if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      b = (pat == 0) ? 8'(k) : (pat == 1) ? 8'hFF : 8'($urandom);
      data_valid = 1'b1;
      data_in    = b;
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("in_reset_op_ready", 128'(operation_ready), 128'(1'b0));
        chk("in_reset_data_ready", 128'(data_ready), 128'(1'b1));
        step();
        rst_n      = 1'b1;
        data_valid = 1'b0;
        core_idle  = 1'b1;
        m_mode     = 3'b000;
        m_bytes.delete();
        #1;
        chk_regs("after_reset");
        chk("after_reset_mode_err", 128'(mode_err), 128'(1'b0));
        chk("after_reset_data_ready", 128'(data_ready), 128'(1'b1));
        return;
      end
      if (k == abort_at) begin
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        data_valid = 1'b0;
        core_idle  = 1'b1;
        chk_regs("after_abort");
        return;
      end
      chk("load_data_ready", 128'(data_ready), 128'(1'b1));
      m_bytes.push_back(b);
      if (k == target - 1 && abort_at != target) exp_q.push_back(mk_ev(1'b0));
      step();
    end
    data_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_data_ready", 128'(data_ready), 128'(1'b0));
      chk("hold_op_ready", 128'(operation_ready), 128'(1'b0));
      data_valid = 1'($urandom);
      data_in    = 8'($urandom);
      step();
    end
    data_valid = 1'b1;
    data_in    = 8'($urandom);
    if (abort_at == target) begin
      load_abort = 1'b1;
      core_idle  = 1'($urandom);
      #1;
      chk("ready_abort_op_ready", 128'(operation_ready), 128'(1'b0));
      step();
      load_abort = 1'b0;
    end else begin
      core_idle = 1'b1;
      #1;
      chk("launch_strobe", 128'(operation_ready), 128'(1'b1));
      chk("launch_data_ready", 128'(data_ready), 128'(1'b0));
      step();
    end
    data_valid = 1'b0;
    core_idle  = 1'b1;
    #1;
    chk("post_launch_op_ready", 128'(operation_ready), 128'(1'b0));
    chk("post_launch_data_ready", 128'(data_ready), 128'(1'b1));
    chk_regs("post_launch");
  endtask

  initial begin
    logic [7:0] hdr;
    int         tgt;
    int         ab;

    rst_n = 1'b0;
    #1;
    chk("reset_op_ready", 128'(operation_ready), 128'(1'b0));
    chk("reset_data_ready", 128'(data_ready), 128'(1'b1));
    step();
    step();
    rst_n = 1'b1;
    chk("init_reg0", reg0_128b, 128'h0);
    chk("init_reg1", reg1_128b, 128'h0);
    chk("init_reg2", reg2_128b, 128'h0);
    chk("init_mode", 128'(operation_mode), 128'(3'b000));
    chk("init_mode_err", 128'(mode_err), 128'(1'b0));
    chk("init_op_ready", 128'(operation_ready), 128'(1'b0));
    chk("init_data_ready", 128'(data_ready), 128'(1'b1));

    // Encrypt, incrementing bytes back-to-back, launch right after the last byte.
    do_load(8'h01, 0, 0, 0, -1, -1);
    chk("enc_reg0", reg0_128b, 128'h000102030405060708090a0b0c0d0e0f);
    chk("enc_reg1", reg1_128b, 128'h101112131415161718191a1b1c1d1e1f);
    chk("enc_reg2", reg2_128b, 128'h202122232425262728292a2b2c2d2e2f);
    chk("enc_mode", 128'(operation_mode), 128'(3'b001));

    // Hash, 0xFF bytes with data_valid toggling.
    do_load(8'h03, 1, 1, 0, -1, -1);
    chk("hash_reg0", reg0_128b, {128{1'b1}});
    chk("hash_reg1", reg1_128b, 128'h0);
    chk("hash_reg2", reg2_128b, 128'h0);

    // Rejected headers, each separated by an idle cycle.
    send_hdr(8'h06);
    idle_cycle();
    send_hdr(8'h07);
    idle_cycle();
    send_hdr(8'h00);
    idle_cycle();
    idle_cycle();
    chk_regs("after_bad_hdr");

    // Header presented with abort in IDLE is ignored; a following bad header
    // must still be decoded as a header.
    load_abort = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'h01;
    step();
    load_abort = 1'b0;
    send_hdr(8'h07);
    idle_cycle();

    // Launch held off by a busy core for 20 cycles.
    do_load(8'h01, 2, 0, 20, -1, -1);

    // Abort on the 6th byte, then a clean decrypt load.
    do_load(8'h01, 2, 0, 0, 5, -1);
    do_load(8'h02, 2, 2, 1, -1, -1);

    // Reset mid-load (byte 30), upper header bits set, then a fresh load.
    do_load(8'hF9, 2, 0, 0, -1, 30);
    do_load(8'h01, 2, 2, 0, -1, -1);

    // Randomized loads.
    for (int t = 0; t < 30; t++) begin
      hdr = 8'($urandom);
      if (!good_mode(hdr[2:0])) begin
        send_hdr(hdr);
        idle_cycle();
      end else begin
        tgt = (hdr[2:0] == 3'b001 || hdr[2:0] == 3'b010) ? 48 : 16;
        ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, tgt)) : -1;
        do_load(hdr, 2, 2, int'($urandom_range(0, 3)), ab, -1);
      end
    end

    repeat (5) idle_cycle();
    chk("events_outstanding", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ascon_loader.md
ASCON_LOADER -- requirements
Module: ascon_loader

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low, sampled on rising edge of clk.
REQ-004 data_in  input  8  byte stream: header byte, then payload bytes.
REQ-005 data_valid  input  1  data_in valid this cycle.
REQ-006 data_ready  output  1  loader accepts data_in this cycle; a byte transfers when data_valid and data_ready are both high at a rising edge.
REQ-007 load_abort  input  1  discard the load in progress and return to IDLE.
REQ-008 core_idle  input  1  downstream permutation controller is idle and can take a launch.
REQ-009 reg0_128b / reg1_128b / reg2_128b  output  128 each  assembled operand registers for the downstream controller.
REQ-010 operation_mode  output  3  registered mode (001 encrypt, 010 decrypt, 011 hash, 100 XOF, 101 CXOF).
REQ-011 operation_ready  output  1  launch strobe to the downstream controller.
REQ-012 mode_err  output  1  one-cycle pulse on a rejected header.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, READY; a 6-bit byte counter SHALL index payload bytes.
REQ-014 data_ready SHALL be 1 in IDLE and LOAD and 0 in READY.
REQ-015 IDLE, header accepted, data_in[2:0] in {001,010}: operation_mode <= data_in[2:0]; target count 48; all three regs cleared to 0; counter <= 0; next state LOAD.
REQ-016 IDLE, header accepted, data_in[2:0] in {011,100,101}: same as REQ-015 with target count 16.
REQ-017 IDLE, header accepted, data_in[2:0] in {000,110,111}: mode_err = 1 the following cycle for exactly one cycle; state stays IDLE; regs and operation_mode unchanged.
REQ-018 data_in[7:3] of the header SHALL be ignored.
REQ-019 LOAD, byte k accepted (k = counter): written to reg(k/16) bits [127-8*(k%16) -: 8], i.e. MSB-first; counter <= k+1.
REQ-020 LOAD, accepted byte is k = target-1: next state READY.
REQ-021 No bytes are accepted in cycles where data_valid is 0; the counter and registers hold.
REQ-022 READY: operation_ready = 1 (combinational) iff core_idle = 1; in that cycle the next state is IDLE.
REQ-023 READY with core_idle = 0: hold READY, operation_ready = 0, with no timeout.
REQ-024 operation_ready SHALL never be high outside READY and SHALL be high for at most one cycle per load.
REQ-025 reg0/1/2_128b and operation_mode SHALL hold their values after launch until the next valid header is accepted.
REQ-026 load_abort = 1 in LOAD or READY: next state IDLE; operation_ready = 0 that cycle; any byte presented that cycle is not written (abort wins over a simultaneous transfer and over core_idle).
REQ-027 load_abort in IDLE: no effect; a header presented in the same cycle is not accepted.
REQ-028 Registers written before an abort SHALL keep their partial contents.
REQ-029 A byte presented in the launch cycle SHALL NOT be accepted (data_ready = 0).

Reset
REQ-030 rst_n = 0 at a rising edge: state IDLE; counter 0; reg0/1/2_128b = 0; operation_mode = 000; mode_err = 0.
REQ-031 During reset and in the first cycle after it: operation_ready = 0, data_ready = 1.
REQ-032 Reset mid-LOAD or in READY: the load is discarded and no operation_ready pulse is issued.
REQ-033 Reset SHALL have priority over every other input.

Verification
REQ-034 Encrypt load: header 0x01, then bytes 0x00..0x2F back-to-back, core_idle = 1 -> reg0 = 0x000102..0F, reg1 = 0x1011..1F, reg2 = 0x2021..2F, operation_mode = 001, operation_ready high exactly one cycle, occurring the cycle after the 48th byte.
REQ-035 Hash load: header 0x03, then 16 bytes 0xFF with data_valid toggled every other cycle -> reg0 = all ones, reg1 = reg2 = 0, operation_ready after the 16th accepted byte only.
REQ-036 Bad header 0x06, then 0x07, then 0x00 -> three single-cycle mode_err pulses; state stays IDLE; outputs unchanged.
REQ-037 Encrypt load with core_idle = 0 for 20 cycles after the last byte -> READY held, data_ready = 0, operation_ready = 0; launch in the first cycle core_idle = 1.
REQ-038 load_abort after 5 payload bytes, coincident with a valid 6th byte -> IDLE next cycle; reg0[127:88] written, 6th byte not written; a subsequent header 0x02 starts a clean load with regs cleared.
REQ-039 rst_n = 0 for one cycle mid-LOAD (byte 30) -> all outputs at reset values; no operation_ready pulse; a fresh load then completes normally.
